// File: rtl/log_capture_pkg.sv
// Shared widths, FSM encoding and status-flag positions for the log-capture buffer.
// Consumed by log_capture and by the micro-side register map.
package log_capture_pkg;

    localparam int NB_GPIOS    = 32;
    localparam int NB_LOG_DATA = 16;
    localparam int NB_LOG_ADDR = 10;

    // Status flags occupy the two top bits of the returned word.
    localparam int FULL_BIT = NB_GPIOS - 1;
    localparam int BUSY_BIT = NB_GPIOS - 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/log_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module log_capture_ram #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 10
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic [NB_ADDR-1:0] rd_addr,
    output logic [NB_DATA-1:0] rd_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/log_capture.sv
// Run-triggered burst capture into a dual-port buffer, read back word by word by the micro.
// Define LOG_CAPTURE_TRIGGER_EN to hold capture in ARMED until a valid sample with in_trigger=1.
module log_capture #(
    parameter int NB_GPIOS = log_capture_pkg::NB_GPIOS,
    parameter int NB_DATA  = log_capture_pkg::NB_LOG_DATA,
    parameter int NB_ADDR  = log_capture_pkg::NB_LOG_ADDR
) (
    input  logic                clock,
    input  logic                in_reset,
    input  logic                in_run,
    input  logic [NB_ADDR-1:0]  in_read_addr,
    input  logic [NB_DATA-1:0]  in_data,
    input  logic                in_valid,
    input  logic                in_trigger,
    output logic [NB_GPIOS-1:0] out_log_data,
    output logic                out_full,
    output logic                out_busy
);

    import log_capture_pkg::*;

    localparam int NB_PAD = NB_GPIOS - NB_DATA - 2;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};

    state_t              state_reg;
    logic [NB_ADDR-1:0]  wr_ptr_reg;
    logic                run_d_reg;
    logic                full_reg;
    logic                busy_reg;
    logic [NB_GPIOS-1:0] log_data_reg;
    logic                start;
    logic                wr_en;
    logic [NB_DATA-1:0]  rd_data;

    assign start = in_run & ~run_d_reg;

`ifdef LOG_CAPTURE_TRIGGER_EN
    always_comb begin
        wr_en = 1'b0;
        if (in_run && in_valid) begin
            case (state_reg)
                ST_CAPTURE: wr_en = 1'b1;
                ST_ARMED:   wr_en = in_trigger;
                default:    wr_en = 1'b0;
            endcase
        end
    end
`else
    logic unused_trigger;
    assign unused_trigger = in_trigger;

    always_comb begin
        wr_en = 1'b0;
        if (in_run && in_valid && state_reg == ST_CAPTURE) begin
            wr_en = 1'b1;
        end
    end
`endif

    // Dropping run aborts a capture; the sample presented in that cycle is not stored.
    always_ff @(posedge clock) begin
        if (in_reset) begin
            state_reg  <= ST_IDLE;
            wr_ptr_reg <= '0;
            run_d_reg  <= 1'b0;
            full_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            run_d_reg <= in_run;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
`ifdef LOG_CAPTURE_TRIGGER_EN
                        state_reg <= ST_ARMED;
`else
                        state_reg <= ST_CAPTURE;
`endif
                        busy_reg   <= 1'b1;
                        full_reg   <= 1'b0;
                        wr_ptr_reg <= '0;
                    end
                end
                ST_ARMED: begin
                    if (!in_run) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (wr_en) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!in_run) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (wr_en && wr_ptr_reg == LAST_ADDR) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        full_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    log_capture_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_data),
        .rd_addr (in_read_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (in_reset) begin
            log_data_reg <= '0;
        end else begin
            log_data_reg <= {full_reg, busy_reg, {NB_PAD{1'b0}}, rd_data};
        end
    end

    assign out_log_data = log_data_reg;
    assign out_full     = full_reg;
    assign out_busy     = busy_reg;

endmodule

// File: tb/tb_log_capture.sv
// Self-checking bench for log_capture: the k-th stored sample after a start must appear at address k.
// Works with or without LOG_CAPTURE_TRIGGER_EN (in_trigger is held high except in the trigger scenario).
module tb_log_capture;

    localparam int NB_GPIOS = 32;
    localparam int NB_DATA  = 16;
    localparam int NB_ADDR  = 10;
    localparam int DEPTH    = 2 ** NB_ADDR;

    logic                clock = 1'b0;
    logic                in_reset;
    logic                in_run;
    logic [NB_ADDR-1:0]  in_read_addr;
    logic [NB_DATA-1:0]  in_data;
    logic                in_valid;
    logic                in_trigger;
    logic [NB_GPIOS-1:0] out_log_data;
    logic                out_full;
    logic                out_busy;

    int errors = 0;
    int checks = 0;

    // Expected buffer contents, indexed by capture order.
    logic [NB_DATA-1:0] model_mem [DEPTH];

    log_capture #(
        .NB_GPIOS (NB_GPIOS),
        .NB_DATA  (NB_DATA),
        .NB_ADDR  (NB_ADDR)
    ) dut (
        .clock        (clock),
        .in_reset     (in_reset),
        .in_run       (in_run),
        .in_read_addr (in_read_addr),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_trigger   (in_trigger),
        .out_log_data (out_log_data),
        .out_full     (out_full),
        .out_busy     (out_busy)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drop then raise run; returns just after the start edge.
    task automatic start_run();
        in_valid = 1'b0;
        in_run   = 1'b0;
        cyc();
        in_run = 1'b1;
        cyc();
    endtask

    task automatic read_word(input int addr, output logic [NB_GPIOS-1:0] word);
        in_read_addr = NB_ADDR'(addr);
        cyc();
        cyc();
        word = out_log_data;
        $display("read addr=%0d word=%h full=%0b busy=%0b", addr, word, out_full, out_busy);
    endtask

    function automatic logic [NB_GPIOS-1:0] pack(input logic f, input logic b, input logic [NB_DATA-1:0] d);
        return {f, b, {(NB_GPIOS - NB_DATA - 2){1'b0}}, d};
    endfunction

    task automatic test_reset();
        in_reset     = 1'b1;
        in_run       = 1'b1;
        in_valid     = 1'b1;
        in_trigger   = 1'b1;
        in_data      = NB_DATA'($urandom);
        in_read_addr = '0;
        repeat (3) cyc();
        checks++;
        if (out_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_full got=%b expected=0", out_full);
        end
        checks++;
        if (out_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b expected=0", out_busy);
        end
        checks++;
        if (out_log_data !== '0) begin
            errors++;
            $display("FAIL reset_log_data got=%h expected=0", out_log_data);
        end
        in_reset = 1'b0;
        in_run   = 1'b0;
        in_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (out_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start got=%b expected=0", out_busy);
        end
        $display("reset done");
    endtask

    task automatic test_full_capture();
        int bad_busy = 0;
        int bad_full = 0;
        logic [NB_GPIOS-1:0] word;
        start_run();
        checks++;
        if (out_busy !== 1'b1 || out_full !== 1'b0) begin
            errors++;
            $display("FAIL full_start busy=%b full=%b expected busy=1 full=0", out_busy, out_full);
        end
        for (int k = 0; k < DEPTH; k++) begin
            in_valid     = 1'b1;
            in_data      = NB_DATA'(k);
            model_mem[k] = NB_DATA'(k);
            cyc();
            if (k < DEPTH - 1) begin
                if (out_busy !== 1'b1) bad_busy++;
                if (out_full !== 1'b0) bad_full++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (bad_busy != 0 || bad_full != 0) begin
            errors++;
            $display("FAIL full_during busy_errs=%0d full_errs=%0d expected 0/0", bad_busy, bad_full);
        end
        checks++;
        if (out_full !== 1'b1 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end full=%b busy=%b expected full=1 busy=0", out_full, out_busy);
        end
        read_word(5, word);
        checks++;
        if (word !== 32'h8000_0005) begin
            errors++;
            $display("FAIL full_addr5 got=%h expected=80000005", word);
        end
        for (int i = 0; i < 3; i++) begin
            int a;
            a = int'($urandom_range(DEPTH - 1, 0));
            read_word(a, word);
            checks++;
            if (word !== pack(1'b1, 1'b0, model_mem[a])) begin
                errors++;
                $display("FAIL full_read addr=%0d got=%h expected=%h", a, word, pack(1'b1, 1'b0, model_mem[a]));
            end
        end
    endtask

    task automatic test_rearm();
        logic [NB_GPIOS-1:0] word;
        in_run = 1'b0;
        cyc();
        checks++;
        if (out_full !== 1'b1) begin
            errors++;
            $display("FAIL rearm_hold got=%b expected=1", out_full);
        end
        in_run = 1'b1;
        cyc();
        checks++;
        if (out_full !== 1'b0 || out_busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_start full=%b busy=%b expected full=0 busy=1", out_full, out_busy);
        end
        for (int k = 0; k < DEPTH; k++) begin
            in_valid     = 1'b1;
            in_data      = NB_DATA'(16'h1000 + k);
            model_mem[k] = NB_DATA'(16'h1000 + k);
            cyc();
        end
        in_valid = 1'b0;
        checks++;
        if (out_full !== 1'b1) begin
            errors++;
            $display("FAIL rearm_full got=%b expected=1", out_full);
        end
        read_word(0, word);
        checks++;
        if (word !== 32'h8000_1000) begin
            errors++;
            $display("FAIL rearm_addr0 got=%h expected=80001000", word);
        end
    endtask

    task automatic test_valid_gaps();
        int bad_full = 0;
        logic [NB_GPIOS-1:0] word;
        start_run();
        for (int c = 0; c < 2 * DEPTH; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = NB_DATA'($urandom);
            if (in_valid) model_mem[c / 2] = in_data;
            cyc();
            if (c < 2 * DEPTH - 2 && out_full !== 1'b0) bad_full++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad_full != 0) begin
            errors++;
            $display("FAIL gaps_early_full count=%0d expected=0", bad_full);
        end
        checks++;
        if (out_full !== 1'b1 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_end full=%b busy=%b expected full=1 busy=0", out_full, out_busy);
        end
        for (int i = 0; i < 4; i++) begin
            int a;
            a = (i == 0) ? DEPTH - 1 : int'($urandom_range(DEPTH - 1, 0));
            read_word(a, word);
            checks++;
            if (word !== pack(1'b1, 1'b0, model_mem[a])) begin
                errors++;
                $display("FAIL gaps_read addr=%0d got=%h expected=%h", a, word, pack(1'b1, 1'b0, model_mem[a]));
            end
        end
    endtask

    task automatic test_abort();
        logic [NB_GPIOS-1:0] word;
        logic [NB_DATA-1:0]  d;
        start_run();
        for (int k = 0; k < 100; k++) begin
            in_valid     = 1'b1;
            in_data      = NB_DATA'($urandom);
            model_mem[k] = in_data;
            cyc();
        end
        in_valid = 1'b0;
        in_run   = 1'b0;
        cyc();
        checks++;
        if (out_busy !== 1'b0 || out_full !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags busy=%b full=%b expected 0/0", out_busy, out_full);
        end
        read_word(99, word);
        checks++;
        if (word !== pack(1'b0, 1'b0, model_mem[99])) begin
            errors++;
            $display("FAIL abort_addr99 got=%h expected=%h", word, pack(1'b0, 1'b0, model_mem[99]));
        end
        read_word(100, word);
        checks++;
        if (word !== pack(1'b0, 1'b0, model_mem[100])) begin
            errors++;
            $display("FAIL abort_addr100 got=%h expected=%h", word, pack(1'b0, 1'b0, model_mem[100]));
        end
        in_run = 1'b1;
        cyc();
        d            = NB_DATA'($urandom);
        in_valid     = 1'b1;
        in_data      = d;
        model_mem[0] = d;
        cyc();
        in_valid = 1'b0;
        in_run   = 1'b0;
        cyc();
        read_word(0, word);
        checks++;
        if (word !== pack(1'b0, 1'b0, d)) begin
            errors++;
            $display("FAIL abort_restart got=%h expected=%h", word, pack(1'b0, 1'b0, d));
        end
    endtask

    task automatic test_read_during_write();
        logic [NB_GPIOS-1:0] word;
        logic [NB_DATA-1:0]  old_d;
        logic [NB_DATA-1:0]  new_d;
        start_run();
        old_d        = model_mem[0];
        new_d        = ~old_d;
        in_read_addr = '0;
        in_valid     = 1'b1;
        in_data      = new_d;
        cyc();
        in_valid = 1'b0;
        cyc();
        model_mem[0] = new_d;
        checks++;
        if (out_log_data !== pack(1'b0, 1'b1, old_d)) begin
            errors++;
            $display("FAIL rdw_old got=%h expected=%h", out_log_data, pack(1'b0, 1'b1, old_d));
        end
        in_run = 1'b0;
        cyc();
        read_word(0, word);
        checks++;
        if (word !== pack(1'b0, 1'b0, new_d)) begin
            errors++;
            $display("FAIL rdw_new got=%h expected=%h", word, pack(1'b0, 1'b0, new_d));
        end
    endtask

    task automatic test_trigger();
        logic [NB_GPIOS-1:0] word;
        int bad_busy = 0;
        in_trigger = 1'b0;
        start_run();
`ifdef LOG_CAPTURE_TRIGGER_EN
        for (int k = 0; k < 50; k++) begin
            in_valid = 1'b1;
            in_data  = NB_DATA'($urandom);
            cyc();
            if (out_busy !== 1'b1) bad_busy++;
        end
        in_trigger   = 1'b1;
        in_data      = 16'hABCD;
        model_mem[0] = 16'hABCD;
        cyc();
        for (int k = 1; k < 10; k++) begin
            in_data      = NB_DATA'($urandom);
            model_mem[k] = in_data;
            cyc();
        end
`else
        for (int k = 0; k < 10; k++) begin
            in_valid     = 1'b1;
            in_data      = (k == 0) ? 16'hABCD : NB_DATA'($urandom);
            model_mem[k] = in_data;
            cyc();
            if (out_busy !== 1'b1) bad_busy++;
        end
`endif
        in_valid   = 1'b0;
        in_run     = 1'b0;
        in_trigger = 1'b1;
        cyc();
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL trig_busy count=%0d expected=0", bad_busy);
        end
        read_word(0, word);
        checks++;
        if (word !== pack(1'b0, 1'b0, 16'hABCD)) begin
            errors++;
            $display("FAIL trig_addr0 got=%h expected=%h", word, pack(1'b0, 1'b0, 16'hABCD));
        end
        read_word(9, word);
        checks++;
        if (word !== pack(1'b0, 1'b0, model_mem[9])) begin
            errors++;
            $display("FAIL trig_addr9 got=%h expected=%h", word, pack(1'b0, 1'b0, model_mem[9]));
        end
    endtask

    initial begin
        test_reset();
        test_full_capture();
        test_rearm();
        test_valid_gaps();
        test_abort();
        test_read_during_write();
        test_trigger();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
